// File: rtl/packet_switch_4port.sv
// packet_switch_4port: one byte-wide input, four byte-wide output FIFOs.
// Packets are framed by data_status and routed by their first byte (DA)
// against four host-programmed port addresses. A packet goes to exactly one
// output FIFO, or it is dropped whole.
module packet_switch_4port #(
   parameter int FIFO_DEPTH = 1024,
   parameter int MAX_PKT    = 259
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_status,
   input  logic [7:0] data,
   input  logic       mem_en,
   input  logic       mem_rd_wr,
   input  logic [1:0] mem_add,
   input  logic [7:0] mem_data,
   output logic       ready_0,
   output logic       ready_1,
   output logic       ready_2,
   output logic       ready_3,
   input  logic       read_0,
   input  logic       read_1,
   input  logic       read_2,
   input  logic       read_3,
   output logic [7:0] port0,
   output logic [7:0] port1,
   output logic [7:0] port2,
   output logic [7:0] port3
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(MAX_PKT + 1);

   logic [7:0]          addr_r [4];
   logic                prev_r;      // data_status seen on the previous edge
   logic                acc_r;       // current packet is being stored
   logic [1:0]          dest_r;      // destination latched on the DA cycle
   logic [PW-1:0]       cnt_r;       // bytes of the current packet stored so far
   logic                is_da_s;
   logic                hit_s;
   logic [1:0]          hit_idx_s;
   logic                room_s;
   logic                wr_s;
   logic [1:0]          wr_dest_s;
   logic [3:0]          rd_s;
   logic [3:0][CW-1:0]  count_s;
   logic [3:0][7:0]     port_s;
   logic [3:0]          ready_s;

   assign rd_s = {read_3, read_2, read_1, read_0};

   // DA detection, lowest-index address match, admission and write steering
   always_comb begin
      is_da_s = data_status & ~prev_r;
      if (data == addr_r[0]) begin
         hit_s = 1'b1; hit_idx_s = 2'd0;
      end else if (data == addr_r[1]) begin
         hit_s = 1'b1; hit_idx_s = 2'd1;
      end else if (data == addr_r[2]) begin
         hit_s = 1'b1; hit_idx_s = 2'd2;
      end else if (data == addr_r[3]) begin
         hit_s = 1'b1; hit_idx_s = 2'd3;
      end else begin
         hit_s = 1'b0; hit_idx_s = 2'd0;
      end
      // a whole maximum-size packet must fit, judged on the DA cycle only
      room_s = (count_s[hit_idx_s] <= CW'(FIFO_DEPTH - MAX_PKT));
      if (is_da_s) begin
         wr_s      = hit_s & room_s;
         wr_dest_s = hit_idx_s;
      end else begin
         wr_s      = data_status & acc_r & (cnt_r < PW'(MAX_PKT));
         wr_dest_s = dest_r;
      end
   end

   // Packet framing state; prev resets high so a packet cut by reset is not re-framed mid-stream
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_r <= 1'b1;
         acc_r  <= 1'b0;
         dest_r <= 2'd0;
         cnt_r  <= '0;
      end else begin
         prev_r <= data_status;
         if (is_da_s) begin
            acc_r  <= hit_s & room_s;
            dest_r <= hit_idx_s;
            cnt_r  <= PW'(1);
         end else if (wr_s) begin
            cnt_r  <= cnt_r + PW'(1);
         end else if (!data_status) begin
            acc_r  <= 1'b0;
         end else begin
            acc_r  <= acc_r;
         end
      end
   end

   // Host configuration writes of the four port addresses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) addr_r[i] <= 8'h00;
      end else if (mem_en && mem_rd_wr) begin
         addr_r[mem_add] <= mem_data;
      end else begin
         addr_r <= addr_r;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_fifo
      logic [7:0]    mem [FIFO_DEPTH];
      logic [AW-1:0] wp_r;
      logic [AW-1:0] rp_r;
      logic [CW-1:0] cnt_r;
      logic [7:0]    port_r;
      logic          ready_r;
      logic          push_s;
      logic          pop_s;
      logic [CW-1:0] cnt_nxt_s;

      // Push/pop decode and next occupancy; reads of an empty FIFO are ignored
      always_comb begin
         push_s    = wr_s && (wr_dest_s == 2'(g));
         pop_s     = rd_s[g] && (cnt_r != '0);
         cnt_nxt_s = cnt_r + CW'(push_s) - CW'(pop_s);
      end

      // Byte storage (no reset needed: occupancy defines validity)
      always_ff @(posedge clk) begin
         if (push_s) mem[wp_r] <= data;
      end

      // Pointers, occupancy, registered ready and output byte
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            wp_r    <= '0;
            rp_r    <= '0;
            cnt_r   <= '0;
            port_r  <= 8'h00;
            ready_r <= 1'b0;
         end else begin
            cnt_r   <= cnt_nxt_s;
            ready_r <= (cnt_nxt_s != '0);
            if (push_s) wp_r <= wp_r + AW'(1);
            if (pop_s) begin
               port_r <= mem[rp_r];
               rp_r   <= rp_r + AW'(1);
            end
         end
      end

      assign count_s[g] = cnt_r;
      assign port_s[g]  = port_r;
      assign ready_s[g] = ready_r;
   end

   assign ready_0 = ready_s[0];
   assign ready_1 = ready_s[1];
   assign ready_2 = ready_s[2];
   assign ready_3 = ready_s[3];
   assign port0   = port_s[0];
   assign port1   = port_s[1];
   assign port2   = port_s[2];
   assign port3   = port_s[3];

endmodule

// File: tb/tb_packet_switch_4port.sv
// Bench for packet_switch_4port: a queue-based reference model checked on
// every cycle, plus literal expectations for the directed scenarios.
module tb_packet_switch_4port;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       data_status = 1'b0;
   logic [7:0] data = 8'h00;
   logic       mem_en = 1'b0;
   logic       mem_rd_wr = 1'b0;
   logic [1:0] mem_add = 2'd0;
   logic [7:0] mem_data = 8'h00;
   logic [3:0] rd = 4'h0;
   logic       ready_0, ready_1, ready_2, ready_3;
   logic [7:0] port0, port1, port2, port3;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   packet_switch_4port dut (
      .clk(clk), .reset(reset), .data_status(data_status), .data(data),
      .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_add(mem_add), .mem_data(mem_data),
      .ready_0(ready_0), .ready_1(ready_1), .ready_2(ready_2), .ready_3(ready_3),
      .read_0(rd[0]), .read_1(rd[1]), .read_2(rd[2]), .read_3(rd[3]),
      .port0(port0), .port1(port1), .port2(port2), .port3(port3)
   );

   always #5 clk = ~clk;

   logic [3:0] rdy_w;
   logic [7:0] pw [4];
   assign rdy_w = {ready_3, ready_2, ready_1, ready_0};
   assign pw[0] = port0;
   assign pw[1] = port1;
   assign pw[2] = port2;
   assign pw[3] = port3;

   // ---------------- reference model ----------------
   logic [7:0] mq [4][$];
   logic [7:0] m_port [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] m_addr [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
   bit         m_prev = 1'b1;
   bit         m_acc = 1'b0;
   int         m_dest = 0;
   int         m_cnt = 0;
   int         m_d;

   // Model: route by DA, admit on free space, cap at 259 bytes, pop before push
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            m_port[i] = 8'h00;
            m_addr[i] = 8'h00;
         end
         m_prev = 1'b1;
         m_acc  = 1'b0;
      end else begin
         if (data_status && !m_prev) begin
            m_d = -1;
            for (int i = 3; i >= 0; i--) if (data == m_addr[i]) m_d = i;
            m_acc  = (m_d >= 0) && ((1024 - mq[m_d].size()) >= 259);
            m_dest = m_d;
            m_cnt  = 0;
         end else if (!data_status) begin
            m_acc = 1'b0;
         end
         for (int i = 0; i < 4; i++)
            if (rd[i] && mq[i].size() > 0) m_port[i] = mq[i].pop_front();
         if (data_status && m_acc && m_cnt < 259) begin
            mq[m_dest].push_back(data);
            m_cnt++;
         end
         if (mem_en && mem_rd_wr) m_addr[mem_add] = mem_data;
         m_prev = data_status;
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rdy_w[i] !== (mq[i].size() != 0)) begin
               n_fail++;
               $display("FAIL model ready_%0d: got %b want %b at %0t", i, rdy_w[i], (mq[i].size() != 0), $time);
            end
            n_chk++;
            if (pw[i] !== m_port[i]) begin
               n_fail++;
               $display("FAIL model port%0d: got %h want %h at %0t", i, pw[i], m_port[i], $time);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic cfg(input logic [1:0] a, input logic [7:0] v, input logic wr);
      mem_en = 1'b1; mem_rd_wr = wr; mem_add = a; mem_data = v;
      step();
      mem_en = 1'b0; mem_rd_wr = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      data_status = 1'b1; data = b;
      step();
   endtask

   task automatic end_pkt();
      data_status = 1'b0; data = 8'h00;
      step();
   endtask

   task automatic send_pkt(input logic [7:0] da, input int n, input logic [7:0] seed);
      for (int i = 0; i < n; i++) begin
         if (i == 0) send_byte(da);
         else send_byte(8'(i * 7) + seed);
      end
      end_pkt();
   endtask

   task automatic drain_all();
      rd = 4'hF;
      for (int k = 0; k < 1100; k++) begin
         if (rdy_w == 4'h0) break;
         step();
      end
      chk("drain_timeout", {12'h0, rdy_w}, 16'h0000);
      rd = 4'h0;
   endtask

   logic [7:0] exp7 [7] = '{8'h20, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h5A};
   int popped;

   initial begin
      step(); step();
      reset = 1'b0;
      step();
      chk_en = 1'b1;
      chk("reset_ready", {12'h0, rdy_w}, 16'h0000);
      chk("reset_port0", {8'h0, port0}, 16'h0000);

      // configure, with an ignored non-write access in between
      cfg(2'd0, 8'h10, 1'b1);
      cfg(2'd1, 8'h20, 1'b1);
      cfg(2'd1, 8'hFF, 1'b0);
      cfg(2'd2, 8'h30, 1'b1);
      cfg(2'd3, 8'h40, 1'b1);

      // basic route to port 1
      for (int k = 0; k < 7; k++) send_byte(exp7[k]);
      end_pkt();
      chk("route1_ready", {12'h0, rdy_w}, 16'h0002);
      rd[1] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         step();
         chk($sformatf("route1_byte%0d", k), {8'h0, port1}, {8'h0, exp7[k]});
      end
      rd[1] = 1'b0;
      chk("route1_empty", {15'h0, ready_1}, 16'h0000);

      // unmatched DA is dropped
      send_pkt(8'h99, 6, 8'h11);
      step();
      chk("nomatch_ready", {12'h0, rdy_w}, 16'h0000);
      chk("nomatch_port1", {8'h0, port1}, 16'h005A);

      // reset in the middle of a packet, data_status still high across release
      send_byte(8'h10);
      send_byte(8'h01);
      reset = 1'b1;
      step();
      chk("midreset_ready", {12'h0, rdy_w}, 16'h0000);
      chk("midreset_port1", {8'h0, port1}, 16'h0000);
      reset = 1'b0;
      send_byte(8'h20);
      send_byte(8'h00);
      end_pkt();
      chk("postreset_ready", {12'h0, rdy_w}, 16'h0000);
      cfg(2'd0, 8'h10, 1'b1);
      cfg(2'd1, 8'h20, 1'b1);
      cfg(2'd2, 8'h30, 1'b1);
      cfg(2'd3, 8'h40, 1'b1);
      send_pkt(8'h10, 5, 8'h21);
      chk("postreset_route", {12'h0, rdy_w}, 16'h0001);
      drain_all();

      // duplicate address: lowest index wins
      cfg(2'd2, 8'h55, 1'b1);
      cfg(2'd3, 8'h55, 1'b1);
      send_pkt(8'h55, 9, 8'h33);
      chk("dup_ready", {12'h0, rdy_w}, 16'h0004);
      drain_all();

      // back-to-back packets to ports 0 and 3 read concurrently;
      // a config write during the first packet only affects later packets
      cfg(2'd3, 8'h40, 1'b1);
      rd = 4'h9;
      send_byte(8'h10);
      mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = 2'd0; mem_data = 8'h77;
      send_byte(8'h02);
      mem_en = 1'b0; mem_rd_wr = 1'b0;
      for (int k = 0; k < 10; k++) send_byte(8'(k + 8'h40));
      end_pkt();
      send_pkt(8'h40, 20, 8'h05);
      for (int k = 0; k < 30; k++) step();
      rd = 4'h0;
      chk("b2b_ready", {12'h0, rdy_w}, 16'h0000);
      cfg(2'd0, 8'h10, 1'b1);

      // fill port 0: 265-byte packet truncated to 259, then 259, 247 -> 765 used
      send_pkt(8'h10, 265, 8'h01);
      send_pkt(8'h10, 259, 8'h02);
      send_pkt(8'h10, 247, 8'h03);
      // exactly 259 free: admitted, FIFO becomes full
      send_pkt(8'h10, 259, 8'h04);
      // no room: dropped whole
      send_pkt(8'h10, 10, 8'h05);
      chk("fill_ready", {12'h0, rdy_w}, 16'h0001);
      rd[0] = 1'b1;
      popped = 0;
      for (int k = 0; k < 1100; k++) begin
         if (!ready_0) break;
         popped++;
         step();
      end
      rd[0] = 1'b0;
      chk("fill_count", 16'(popped), 16'd1024);
      chk("fill_empty", {15'h0, ready_0}, 16'h0000);

      step(); step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
